// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue controller: datapath width, FSM encoding
// and the ALU mode codes.
package alu_issue_pkg;

    localparam int N = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;

    localparam logic [2:0] MODE_ADD = 3'b000;
    localparam logic [2:0] MODE_SUB = 3'b001;
    localparam logic [2:0] MODE_AND = 3'b010;
    localparam logic [2:0] MODE_OR  = 3'b011;
    localparam logic [2:0] MODE_XOR = 3'b100;
    localparam logic [2:0] MODE_NOT = 3'b101;
    localparam logic [2:0] MODE_INC = 3'b110;
    localparam logic [2:0] MODE_DEC = 3'b111;

    // Only add/sub produce a carry/borrow that is kept in flag_c.
    function automatic logic mode_sets_carry(input logic [2:0] mode);
        return (mode == MODE_ADD) || (mode == MODE_SUB);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4-entry register file: three combinational read ports, an external write
// port and a writeback port that wins on an address collision.
module alu_regfile #(
    parameter int W = alu_issue_pkg::N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   ra_addr_i,
    output logic [W-1:0] ra_data_o,
    input  logic [1:0]   rb_addr_i,
    output logic [W-1:0] rb_data_o,
    input  logic [1:0]   rc_addr_i,
    output logic [W-1:0] rc_data_o,
    input  logic         wb_en_i,
    input  logic [1:0]   wb_addr_i,
    input  logic [W-1:0] wb_data_i,
    input  logic         ext_en_i,
    input  logic [1:0]   ext_addr_i,
    input  logic [W-1:0] ext_data_i
);
    import alu_issue_pkg::*;

    logic [W-1:0] regs_q [4];

    assign ra_data_o = regs_q[ra_addr_i];
    assign rb_data_o = regs_q[rb_addr_i];
    assign rc_data_o = regs_q[rc_addr_i];

    // Writeback is issued last so it overrides a same-address external write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            if (ext_en_i) regs_q[ext_addr_i] <= ext_data_i;
            if (wb_en_i)  regs_q[wb_addr_i]  <= wb_data_i;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one command at a time to an external ALU, captures its result and
// writes it back to the register file together with carry/zero flags.
//
// state    | meaning
// IDLE     | ready for a command; operands latched on accept
// ISSUE    | registered operands presented to the ALU; result captured at exit
// WB       | done pulse; result and flags written at exit
module alu_issue_ctrl #(
    parameter int N = alu_issue_pkg::N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_op,
    input  logic [1:0]   in_ra,
    input  logic [1:0]   in_rb,
    input  logic [1:0]   in_rd,
    input  logic         in_use_cb,
    input  logic         wr_en,
    input  logic [1:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [1:0]   rd_addr,
    output logic [N-1:0] rd_data,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_cb_in,
    output logic [2:0]   alu_mode,
    input  logic [N-1:0] alu_result,
    input  logic         alu_cb_out,
    output logic         done,
    output logic         flag_c,
    output logic         flag_z
);
    import alu_issue_pkg::*;

    logic [1:0]   state_q, state_d;
    logic [N-1:0] alu_a_q, alu_b_q, res_q;
    logic [2:0]   alu_mode_q;
    logic         alu_cb_in_q, cout_q;
    logic [1:0]   rd_q;
    logic         flag_c_q, flag_z_q;
    logic [N-1:0] ra_data, rb_data;
    logic         accept, wb_fire;

    assign accept  = in_valid && (state_q == ST_IDLE);
    assign wb_fire = (state_q == ST_WB);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_mode_q  <= MODE_ADD;
            alu_cb_in_q <= 1'b0;
            rd_q        <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a_q     <= ra_data;
                alu_b_q     <= rb_data;
                alu_mode_q  <= in_op;
                alu_cb_in_q <= in_use_cb & flag_c_q;
                rd_q        <= in_rd;
            end
            if (state_q == ST_ISSUE) begin
                res_q  <= alu_result;
                cout_q <= alu_cb_out;
            end
            if (wb_fire) begin
                flag_c_q <= mode_sets_carry(alu_mode_q) & cout_q;
                flag_z_q <= (res_q == '0);
            end
        end
    end

    alu_regfile #(.W(N)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .ra_addr_i  (in_ra),
        .ra_data_o  (ra_data),
        .rb_addr_i  (in_rb),
        .rb_data_o  (rb_data),
        .rc_addr_i  (rd_addr),
        .rc_data_o  (rd_data),
        .wb_en_i    (wb_fire),
        .wb_addr_i  (rd_q),
        .wb_data_i  (res_q),
        .ext_en_i   (wr_en),
        .ext_addr_i (wr_addr),
        .ext_data_i (wr_data)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign done      = wb_fire;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_mode  = alu_mode_q;
    assign alu_cb_in = alu_cb_in_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU drives the alu_*
// inputs, and an array model of the registers/flags predicts results.
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [2:0]   in_op;
    logic [1:0]   in_ra, in_rb, in_rd;
    logic         in_use_cb;
    logic         wr_en;
    logic [1:0]   wr_addr;
    logic [N-1:0] wr_data;
    logic [1:0]   rd_addr;
    logic [N-1:0] rd_data;
    logic [N-1:0] alu_a, alu_b, alu_result;
    logic         alu_cb_in, alu_cb_out;
    logic [2:0]   alu_mode;
    logic         done, flag_c, flag_z;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] m_r [4];
    logic         m_c, m_z;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_use_cb(in_use_cb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cb_in(alu_cb_in), .alu_mode(alu_mode),
        .alu_result(alu_result), .alu_cb_out(alu_cb_out),
        .done(done), .flag_c(flag_c), .flag_z(flag_z)
    );

    // Returns {carry/borrow, result} using plain integer arithmetic.
    function automatic logic [N:0] alu_ref(input logic [2:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b, input logic cin);
        int t;
        int lim = 1 << N;
        case (op)
            3'b000: t = int'(a) + int'(b) + int'(cin);
            3'b001: t = int'(a) - int'(b) - int'(cin);
            3'b010: t = int'(a & b);
            3'b011: t = int'(a | b);
            3'b100: t = int'(a ^ b);
            3'b101: t = int'(~a);
            3'b110: t = int'(a) + 1;
            default: t = int'(a) - 1;
        endcase
        return {(t < 0) || (t >= lim), N'((t + 2 * lim) % lim)};
    endfunction

    always_comb {alu_cb_out, alu_result} = alu_ref(alu_mode, alu_a, alu_b, alu_cb_in);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            chk($sformatf("R%0d", a), 32'(rd_data), 32'(m_r[a]));
        end
        chk("flag_c", 32'(flag_c), 32'(m_c));
        chk("flag_z", 32'(flag_z), 32'(m_z));
    endtask

    task automatic load(input logic [1:0] a, input logic [N-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        m_r[a] = d;
    endtask

    // Called in IDLE just after a falling edge; returns three cycles later in IDLE.
    task automatic run_cmd(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                           input logic [1:0] rd, input logic ucb,
                           input logic acc_we, input logic [1:0] acc_wa, input logic [N-1:0] acc_wd,
                           input logic wb_we, input logic [1:0] wb_wa, input logic [N-1:0] wb_wd,
                           input logic hold_valid);
        logic [N-1:0] ea, eb;
        logic         ecb;
        logic [N:0]   r;
        ea  = m_r[ra];
        eb  = m_r[rb];
        ecb = ucb ? m_c : 1'b0;
        in_valid = 1'b1; in_op = op; in_ra = ra; in_rb = rb; in_rd = rd; in_use_cb = ucb;
        wr_en = acc_we; wr_addr = acc_wa; wr_data = acc_wd;
        if (acc_we) m_r[acc_wa] = acc_wd;
        chk("ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = hold_valid; wr_en = 1'b0;
        chk("alu_a", 32'(alu_a), 32'(ea));
        chk("alu_b", 32'(alu_b), 32'(eb));
        chk("alu_mode", 32'(alu_mode), 32'(op));
        chk("alu_cb_in", 32'(alu_cb_in), 32'(ecb));
        chk("done_issue", 32'(done), 32'd0);
        chk("ready_issue", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("done_wb", 32'(done), 32'd1);
        chk("ready_wb", 32'(in_ready), 32'd0);
        chk("alu_a_held", 32'(alu_a), 32'(ea));
        wr_en = wb_we; wr_addr = wb_wa; wr_data = wb_wd;
        r = alu_ref(op, ea, eb, ecb);
        if (wb_we && wb_wa != rd) m_r[wb_wa] = wb_wd;
        m_r[rd] = r[N-1:0];
        m_c = (op == 3'b000 || op == 3'b001) ? r[N] : 1'b0;
        m_z = (r[N-1:0] == '0);
        @(negedge clk);
        wr_en = 1'b0;
        chk("done_after", 32'(done), 32'd0);
        chk("ready_after", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        check_state();
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [1:0]   ra, rb, rd;
        logic         ucb;
        logic         hold;
        logic [N-1:0] exp_res;
        logic         exp_c, exp_z;
    } vec_t;

    vec_t vecs [3];

    initial begin
        vecs[0] = '{3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0};
        vecs[1] = '{3'b000, 2'd0, 2'd1, 2'd3, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0};
        vecs[2] = '{3'b100, 2'd0, 2'd0, 2'd1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_ra = '0; in_rb = '0; in_rd = '0;
        in_use_cb = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_c = 1'b0; m_z = 1'b0;

        // Reset held two cycles.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_mode", 32'(alu_mode), 32'd0);
        chk("rst_cb_in", 32'(alu_cb_in), 32'd0);
        check_state();
        @(negedge clk);

        // Directed table: add, chained add with carry-in, xor to zero with valid held.
        load(2'd0, 4'd9);
        load(2'd1, 4'd8);
        for (int v = 0; v < 3; v++) begin
            run_cmd(vecs[v].op, vecs[v].ra, vecs[v].rb, vecs[v].rd, vecs[v].ucb,
                    1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'd0, vecs[v].hold);
            rd_addr = vecs[v].rd;
            #1;
            chk("tbl_res", 32'(rd_data), 32'(vecs[v].exp_res));
            chk("tbl_c", 32'(flag_c), 32'(vecs[v].exp_c));
            chk("tbl_z", 32'(flag_z), 32'(vecs[v].exp_z));
            @(negedge clk);
            chk("tbl_no_extra_done", 32'(done), 32'd0);
        end

        // Writeback collides with an external write to the same and a different register.
        load(2'd1, 4'd8);
        run_cmd(3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 4'd5, 1'b0);
        rd_addr = 2'd2; #1;
        chk("wb_wins_R2", 32'(rd_data), 32'd1);
        @(negedge clk);
        run_cmd(3'b000, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 2'd3, 4'd5, 1'b0);
        rd_addr = 2'd2; #1;
        chk("both_R2", 32'(rd_data), 32'd1);
        rd_addr = 2'd3; #1;
        chk("both_R3", 32'(rd_data), 32'd5);
        @(negedge clk);

        // Operands are read before a same-edge external write to the source.
        run_cmd(3'b001, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 2'd0, 4'd2, 1'b0, 2'd0, 4'd0, 1'b0);
        @(negedge clk);

        // Randomized commands with optional colliding writes and held valid.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) load(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            run_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Reset during ISSUE aborts the command and overrides an external write.
        @(negedge clk);
        load(2'd0, 4'd3);
        load(2'd1, 4'd4);
        in_valid = 1'b1; in_op = 3'b000; in_ra = 2'd0; in_rb = 2'd1; in_rd = 2'd2; in_use_cb = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_in_issue", 32'(in_ready), 32'd0);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'd7;
        @(negedge clk);
        chk("abort_idle", 32'(in_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        rst = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_c = 1'b0; m_z = 1'b0;
        check_state();
        @(negedge clk);
        chk("abort_done_later", 32'(done), 32'd0);
        chk("abort_alu_a", 32'(alu_a), 32'd0);
        check_state();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
